// File: rtl/dff_posneg_pair.sv
// dff_posneg_pair: rising-edge flop feeding a falling-edge flop, with true/complement outputs
module dff_posneg_pair #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_pos,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);
    always_ff @(posedge clk or posedge reset)
        if (reset) q_pos <= RESET_VALUE;
        else       q_pos <= d;
    // q moves only on the falling edge, so q & clk never produces a runt pulse
    always_ff @(negedge clk or posedge reset)
        if (reset) q <= RESET_VALUE;
        else       q <= q_pos;
    assign qn = ~q;
endmodule

// File: tb/tb_dff_posneg_pair.sv
// tb_dff_posneg_pair: randomized check of WIDTH=1 and WIDTH=4 pos/neg flop pairs
module tb_dff_posneg_pair;
    logic       clk = 1'b0;
    logic       rst1, rst4, d1;
    logic [3:0] d4;
    logic       q_pos1, q1, qn1;
    logic [3:0] q_pos4, q4, qn4;
    logic       e1;
    logic [3:0] e4;
    int         vectors = 0, miscompares = 0;
    bit         mon = 1'b0;
    time        t_rise = 0;
    logic       seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    dff_posneg_pair #(.WIDTH(1), .RESET_VALUE(1'b0)) u1 (
        .clk(clk), .reset(rst1), .d(d1), .q_pos(q_pos1), .q(q1), .qn(qn1));
    dff_posneg_pair #(.WIDTH(4), .RESET_VALUE(4'b1010)) u4 (
        .clk(clk), .reset(rst4), .d(d4), .q_pos(q_pos4), .q(q4), .qn(qn4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(clk) begin
        #1;
        chk("qn_inv1", 32'(qn1), 32'(1'(~q1)));
        chk("qn_inv4", 32'(qn4), 32'(4'(~q4)));
    end

    wire g = q1 & clk;
    always @(posedge g) t_rise = $time;
    always @(negedge g) if (mon) chk("gate_width", 32'($time - t_rise), 32'd5);
    always @(q1) if (mon) chk("q1_chg_low", 32'(clk), 32'd0);
    always @(q4) if (mon) chk("q4_chg_low", 32'(clk), 32'd0);

    task automatic check_all(input string tag);
        chk({tag, "_qpos1"}, 32'(q_pos1), 32'(e1));
        chk({tag, "_q1"}, 32'(q1), 32'(e1));
        chk({tag, "_qpos4"}, 32'(q_pos4), 32'(e4));
        chk({tag, "_q4"}, 32'(q4), 32'(e4));
    endtask

    // Apply one value while clk is low; expect it on q_pos at the rising edge
    // and on q half a period later, with q holding its old value in between.
    task automatic cycle(input logic v1, input logic [3:0] v4);
        d1 = v1;
        d4 = v4;
        @(posedge clk); #1;
        chk("qpos1", 32'(q_pos1), 32'(v1));
        chk("qpos4", 32'(q_pos4), 32'(v4));
        chk("q1_hold", 32'(q1), 32'(e1));
        chk("q4_hold", 32'(q4), 32'(e4));
        @(negedge clk); #1;
        e1 = v1;
        e4 = v4;
        chk("q1", 32'(q1), 32'(e1));
        chk("q4", 32'(q4), 32'(e4));
    endtask

    initial begin
        rst1 = 1'b0; rst4 = 1'b0; d1 = 1'b0; d4 = 4'h0;
        #2 rst1 = 1'b1; rst4 = 1'b1;
        e1 = 1'b0; e4 = 4'b1010;
        #1 check_all("rst_imm");
        d1 = 1'b1; d4 = 4'b0101;
        repeat (3) begin
            @(posedge clk); #1 check_all("rst_hold_r");
            @(negedge clk); #1 check_all("rst_hold_f");
        end
        @(posedge clk); #2 rst1 = 1'b0; rst4 = 1'b0;
        #1 check_all("rel_nochg");
        d1 = 1'b1; d4 = 4'b0110;
        @(negedge clk); #1 check_all("rel_first_fall");
        cycle(1'b1, 4'b0110);
        foreach (seq[i]) cycle(seq[i], 4'($urandom));
        mon = 1'b1;
        repeat (40) cycle(1'($urandom), 4'($urandom));
        mon = 1'b0;
        cycle(1'b1, 4'b1111);
        rst1 = 1'b1; rst4 = 1'b1;
        e1 = 1'b0; e4 = 4'b1010;
        #1 check_all("rst_low");
        @(posedge clk); #1 check_all("rst_low_hold");
        #1 rst1 = 1'b0; rst4 = 1'b0;
        d1 = 1'b1; d4 = 4'b0011;
        @(negedge clk); #1 check_all("rel2_first_fall");
        cycle(1'b1, 4'b0011);
        d1 = 1'b0; d4 = 4'b0101;
        @(posedge clk); #2 rst1 = 1'b1; rst4 = 1'b1;
        e1 = 1'b0; e4 = 4'b1010;
        #1 check_all("rst_high");
        @(negedge clk); #1 check_all("rst_high_discard");
        #1 rst1 = 1'b0; rst4 = 1'b0;
        cycle(1'b1, 4'b1001);
        repeat (10) cycle(1'($urandom), 4'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
